// File: rtl/dcm_update_ctrl.sv
// -----------------------------------------------------------------------------
// dcm_update_ctrl
//
// Front-end for the clock manager (dcm). Synchronises and debounces the raw
// update push-button and the 3-bit frequency-select switches. For each
// accepted update it emits a one-cycle update pulse. Alongside the pulse it
// presents a select code that was latched at that same edge. The dcm samples
// prog_sel on the pulse to reprogram its slow clock.
//
// Optional build macro: UPDATE_REPEAT_EN
//   Defined     : while the button stays held, a further update fires every
//                 REPEAT_CYCLES clocks. Each repeat re-latches the switches.
//   Not defined : exactly one update per debounced press.
//
// Parameters:
//   DEBOUNCE_CYCLES  clk cycles the button must be stable (minimum 2)
//   REPEAT_CYCLES    auto-repeat interval; used only with UPDATE_REPEAT_EN
//
// Ports:
//   clk           in   reference clock, all logic on posedge
//   rst           in   asynchronous, active-high reset
//   btn_update    in   raw update button (async, bouncy), high = pressed
//   prog_sw[2:0]  in   raw frequency-select switches (async)
//   update_pulse  out  one-cycle strobe per accepted update
//   prog_sel[2:0] out  select code latched on each update
//   busy          out  high while the button FSM is not idle
//   upd_count[7:0] out accepted updates, modulo 256
// -----------------------------------------------------------------------------
module dcm_update_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_update,
  input  logic [2:0] prog_sw,
  output logic       update_pulse,
  output logic [2:0] prog_sel,
  output logic       busy,
  output logic [7:0] upd_count
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("dcm_update_ctrl: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);
`ifdef UPDATE_REPEAT_EN
  localparam logic [31:0] REP_LAST = 32'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM_PRESS,
    HELD,
    CONFIRM_RELEASE
  } state_t;

  // Input synchronisers. Nothing else looks at the raw pins.
  logic       btn_s1_q, btn_s_q;
  logic [2:0] sw_s1_q,  sw_s_q;

  state_t      state_q, state_d;
  logic [31:0] cnt_q,   cnt_d;
  logic        fire;

  logic       update_pulse_q, update_pulse_d;
  logic [2:0] prog_sel_q,     prog_sel_d;
  logic       busy_q,         busy_d;
  logic [7:0] upd_count_q,    upd_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q <= 1'b0;
      btn_s_q  <= 1'b0;
      sw_s1_q  <= '0;
      sw_s_q   <= '0;
    end else begin
      btn_s1_q <= btn_update;
      btn_s_q  <= btn_s1_q;
      sw_s1_q  <= prog_sw;
      sw_s_q   <= sw_s1_q;
    end
  end

  // Button debounce FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = CONFIRM_PRESS;
          cnt_d   = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = '0;
        end
`ifdef UPDATE_REPEAT_EN
        // Release takes priority over a repeat that falls due on the same edge.
        else if (cnt_q == REP_LAST) begin
          cnt_d = '0;
          fire  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      CONFIRM_RELEASE: begin
        if (btn_s_q) begin
          // Release bounce: back to HELD. The repeat interval restarts there.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output registers. Everything a fire changes is registered on the same
  // edge, so prog_sel already carries the new code during the pulse cycle.
  always_comb begin
    update_pulse_d = fire;
    prog_sel_d     = fire ? sw_s_q : prog_sel_q;
    upd_count_d    = upd_count_q + {7'd0, fire};
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_pulse_q <= 1'b0;
      prog_sel_q     <= '0;
      busy_q         <= 1'b0;
      upd_count_q    <= '0;
    end else begin
      update_pulse_q <= update_pulse_d;
      prog_sel_q     <= prog_sel_d;
      busy_q         <= busy_d;
      upd_count_q    <= upd_count_d;
    end
  end

  assign update_pulse = update_pulse_q;
  assign prog_sel     = prog_sel_q;
  assign busy         = busy_q;
  assign upd_count    = upd_count_q;

endmodule
